// File: rtl/dmem_ctrl.sv
// Data-memory controller: byte-addressed sync RAM with sub-word access behind a valid/ready port.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (fault detection and resp_err).
module dmem_ctrl #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2,
  localparam int unsigned ADDR_W = $clog2(DEPTH) + 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);
  localparam int unsigned WIDX_W = ADDR_W - 2;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, valid_q, err_q;
  logic [31:0]       rdata_q;
  logic [1:0]        size_q, lane_q;
  logic              uns_q, fault_q;
  logic [31:0]       word_q;
  logic [31:0]       mem [DEPTH];

  logic              accept_c, fault_c, resp_err_c;
  logic [1:0]        size_eff_c, lane_c;
  logic [WIDX_W-1:0] widx_c;
  logic [3:0]        be_c;
  logic [31:0]       wdata_rep_c, rd_word_c, resp_rdata_c;

  // Lane select and sign/zero extension of a little-endian word.
  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                          input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {lane, 3'b000});
    h = 16'(word >> {lane[1], 4'b0000});
    case (size)
      2'b00:   extract = uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   extract = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: extract = word;
    endcase
  endfunction

  assign accept_c = req_valid && ready_q;
  assign widx_c   = req_addr[ADDR_W-1:2];

  // Fault detection or force-alignment, byte enables and lane-replicated store data.
  always_comb begin
    size_eff_c = req_size;
    lane_c     = req_addr[1:0];
    fault_c    = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    case (req_size)
      2'b01:   fault_c = req_addr[0];
      2'b10:   fault_c = |req_addr[1:0];
      2'b11:   fault_c = 1'b1;
      default: fault_c = 1'b0;
    endcase
`else
    if (req_size == 2'b11) size_eff_c = 2'b10;
    if (size_eff_c == 2'b01) lane_c[0] = 1'b0;
    if (size_eff_c == 2'b10) lane_c = 2'b00;
`endif
    case (size_eff_c)
      2'b00: begin
        be_c        = 4'b0001 << lane_c;
        wdata_rep_c = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_c        = lane_c[1] ? 4'b1100 : 4'b0011;
        wdata_rep_c = {2{req_wdata[15:0]}};
      end
      default: begin
        be_c        = 4'b1111;
        wdata_rep_c = req_wdata;
      end
    endcase
    rd_word_c = (req_write || fault_c) ? 32'h0 : mem[widx_c];
  end

  // Response source: live request when entering RESP straight from IDLE, latched otherwise.
  always_comb begin
    resp_rdata_c = extract(word_q, size_q, lane_q, uns_q);
    resp_err_c   = fault_q;
    if (state_q == IDLE) begin
      resp_rdata_c = extract(rd_word_c, size_eff_c, lane_c, req_unsigned);
      resp_err_c   = fault_c;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = (LATENCY > 1) ? BUSY : RESP;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      size_q  <= '0;
      lane_q  <= '0;
      uns_q   <= 1'b0;
      fault_q <= 1'b0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == IDLE);
      valid_q <= (state_d == RESP);
      if (accept_c) begin
        size_q  <= size_eff_c;
        lane_q  <= lane_c;
        uns_q   <= req_unsigned;
        fault_q <= fault_c;
        word_q  <= rd_word_c;
      end
      if (state_d == RESP) begin
        rdata_q <= resp_rdata_c;
        err_q   <= resp_err_c;
      end
    end
  end

  // RAM array: not reset; stores commit at the accept edge.
  always_ff @(posedge clk) begin
    if (rst_n && accept_c && req_write && !fault_c) begin
      for (int b = 0; b < 4; b++) begin
        if (be_c[b]) mem[widx_c][8*b +: 8] <= wdata_rep_c[8*b +: 8];
      end
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: byte-array reference model with per-cycle compare, plus a LATENCY=4 reset instance.
module tb_dmem_ctrl;
  localparam int unsigned LAT_A = 2;
  localparam int unsigned LAT_B = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, req_valid, req_ready, req_write, req_unsigned, resp_valid, resp_err;
  logic [1:0]  req_size;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata, resp_rdata;

  logic        rst_n_b, req_valid_b, req_ready_b, req_write_b, req_unsigned_b, resp_valid_b, resp_err_b;
  logic [1:0]  req_size_b;
  logic [5:0]  req_addr_b;
  logic [31:0] req_wdata_b, resp_rdata_b;

  dmem_ctrl #(.DEPTH(256), .LATENCY(LAT_A)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dmem_ctrl #(.DEPTH(16), .LATENCY(LAT_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n_b), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_write(req_write_b), .req_size(req_size_b), .req_unsigned(req_unsigned_b),
    .req_addr(req_addr_b), .req_wdata(req_wdata_b), .resp_valid(resp_valid_b),
    .resp_rdata(resp_rdata_b), .resp_err(resp_err_b)
  );

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  int          checks = 0;
  int          failures = 0;
  int          ncyc = 0;
  int          acc_ncyc = 0;
  int          last_resp_ncyc = 0;
  logic        chk_en = 1'b0;
  exp_t        expq[$];
  logic [7:0]  mm [1024];
  logic [31:0] held_rdata = 32'h0;
  logic        held_err = 1'b0;
  logic [31:0] last_rdata = 32'h0;
  logic        last_err = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic chk_timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout expected=event", nm);
  endtask

  // Reference: memory as bytes; an access touches nb consecutive bytes from its address.
  task automatic model(input logic w, input logic [1:0] sz, input logic u, input int addr,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int          nb;
    int          a;
    logic [31:0] v;
    nb = (sz == 2'd3) ? 4 : (1 << sz);
    a  = addr;
`ifdef DMEM_MISALIGN_TRAP_EN
    er = (sz == 2'd3) || (addr % nb != 0);
`else
    er = 1'b0;
    a  = addr - (addr % nb);
`endif
    rd = 32'h0;
    if (!er) begin
      if (w) begin
        for (int i = 0; i < nb; i++) mm[a + i] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < nb; i++) v = v | (32'(mm[a + i]) << (8 * i));
        if (!u && nb < 4 && v[8*nb - 1]) begin
          for (int k = 8 * nb; k < 32; k++) v[k] = 1'b1;
        end
        rd = v;
      end
    end
  endtask

  // Every cycle: response pulse, ready and held data must match the expectation queue.
  task automatic compare_loop();
    forever begin
      @(negedge clk);
      ncyc++;
      if (chk_en) begin
        if (expq.size() > 0 && expq[0].due == ncyc) begin
          chk("resp_valid_pulse", 32'(resp_valid), 32'd1);
          chk("req_ready_in_resp", 32'(req_ready), 32'd0);
          chk("resp_rdata", resp_rdata, expq[0].rdata);
          chk("resp_err", 32'(resp_err), 32'(expq[0].err));
          held_rdata     = expq[0].rdata;
          held_err       = expq[0].err;
          last_rdata     = resp_rdata;
          last_err       = resp_err;
          last_resp_ncyc = ncyc;
          void'(expq.pop_front());
        end else begin
          chk("resp_valid_quiet", 32'(resp_valid), 32'd0);
          chk("req_ready", 32'(req_ready), 32'(expq.size() == 0));
          chk("resp_rdata_hold", resp_rdata, held_rdata);
          chk("resp_err_hold", 32'(resp_err), 32'(held_err));
        end
      end
    end
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz, input logic u, input int addr,
                        input logic [31:0] wd);
    int          n;
    logic [31:0] rd;
    logic        er;
    exp_t        e;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk_timeout("req_ready_wait");
      return;
    end
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = 10'(addr); req_wdata = wd;
    @(posedge clk);
    acc_ncyc = ncyc;
    model(w, sz, u, addr, wd, rd, er);
    e.due = ncyc + int'(LAT_A); e.rdata = rd; e.err = er;
    expq.push_back(e);
    #1;
    // Junk while busy must be ignored.
    req_valid = 1'($urandom); req_write = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = 10'($urandom); req_wdata = $urandom;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (expq.size() > 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b0;
    if (expq.size() > 0) begin
      chk_timeout("response_wait");
      expq.delete();
    end
  endtask

  task automatic load_lit(input string nm, input logic [1:0] sz, input logic u, input int addr,
                          input logic [31:0] exp_d, input logic exp_e);
    do_req(1'b0, sz, u, addr, 32'h0);
    wait_idle();
    chk(nm, last_rdata, exp_d);
    chk({nm, "_err"}, 32'(last_err), 32'(exp_e));
  endtask

  task automatic b_req(input logic w, input logic [1:0] sz, input logic u, input int addr,
                       input logic [31:0] wd);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready_b && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready_b) chk_timeout("b_ready_wait");
    req_valid_b = 1'b1; req_write_b = w; req_size_b = sz; req_unsigned_b = u;
    req_addr_b = 6'(addr); req_wdata_b = wd;
    @(posedge clk);
    #1 req_valid_b = 1'b0;
  endtask

  task automatic b_resp(input string nm, input logic [31:0] exp_d);
    int lat;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (resp_valid_b) break;
    end
    if (!resp_valid_b) begin
      chk_timeout({nm, "_resp"});
    end else begin
      chk({nm, "_latency"}, 32'(lat), 32'(LAT_B));
      chk({nm, "_rdata"}, resp_rdata_b, exp_d);
      chk({nm, "_err"}, 32'(resp_err_b), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    fork
      compare_loop();
    join_none
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    rst_n_b = 1'b0; req_valid_b = 1'b0; req_write_b = 1'b0; req_size_b = 2'd0;
    req_unsigned_b = 1'b0; req_addr_b = '0; req_wdata_b = '0;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", 32'(req_ready), 32'd1);
    chk_en = 1'b1;

    for (int i = 0; i < 16; i++) do_req(1'b1, 2'd2, 1'b0, i * 4, $urandom);
    wait_idle();

    do_req(1'b1, 2'd2, 1'b0, 'h10, 32'hDEADBEEF);
    wait_idle();
    chk("store_rdata_zero", last_rdata, 32'h0);
    chk("resp_latency", 32'(last_resp_ncyc - acc_ncyc), 32'(LAT_A));
    load_lit("word_rt", 2'd2, 1'b0, 'h10, 32'hDEADBEEF, 1'b0);
    chk("load_latency", 32'(last_resp_ncyc - acc_ncyc), 32'(LAT_A));

    do_req(1'b1, 2'd0, 1'b0, 'h13, 32'h0000005A);
    do_req(1'b1, 2'd1, 1'b0, 'h10, 32'h00001234);
    wait_idle();
    load_lit("merge_word", 2'd2, 1'b0, 'h10, 32'h5AAD1234, 1'b0);
    load_lit("byte_pos_signed", 2'd0, 1'b0, 'h13, 32'h0000005A, 1'b0);
    do_req(1'b1, 2'd0, 1'b0, 'h11, 32'h00000080);
    wait_idle();
    load_lit("byte_neg_signed", 2'd0, 1'b0, 'h11, 32'hFFFFFF80, 1'b0);
    load_lit("byte_neg_unsigned", 2'd0, 1'b1, 'h11, 32'h00000080, 1'b0);
    load_lit("half_hi_signed", 2'd1, 1'b0, 'h12, 32'h00005AAD, 1'b0);

`ifdef DMEM_MISALIGN_TRAP_EN
    do_req(1'b1, 2'd2, 1'b0, 'h12, 32'hFFFFFFFF);
    wait_idle();
    chk("misalign_store_err", 32'(last_err), 32'd1);
    load_lit("misalign_unchanged", 2'd2, 1'b0, 'h10, 32'h5AAD8034, 1'b0);
    load_lit("misalign_half", 2'd1, 1'b0, 'h11, 32'h0, 1'b1);
    load_lit("reserved_size", 2'd3, 1'b0, 'h10, 32'h0, 1'b1);
`else
    load_lit("forced_half", 2'd1, 1'b0, 'h11, 32'hFFFF8034, 1'b0);
    load_lit("size3_as_word", 2'd3, 1'b1, 'h12, 32'h5AAD8034, 1'b0);
`endif

    do_req(1'b1, 2'd2, 1'b0, 'h3FC, 32'hA5A50F0F);
    wait_idle();
    load_lit("top_half_unsigned", 2'd1, 1'b1, 'h3FE, 32'h0000A5A5, 1'b0);

    for (int i = 0; i < 300; i++) begin
      do_req(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
             int'($urandom_range(0, 63)), $urandom);
    end
    wait_idle();

    // Second instance: LATENCY=4 timing and reset behaviour.
    repeat (3) @(negedge clk);
    chk("b_rst_ready", 32'(req_ready_b), 32'd0);
    rst_n_b = 1'b1;
    @(negedge clk);
    chk("b_ready_after_release", 32'(req_ready_b), 32'd1);
    b_req(1'b1, 2'd2, 1'b0, 'h4, 32'h11223344);
    b_resp("b_store", 32'h0);
    b_req(1'b0, 2'd2, 1'b0, 'h4, 32'h0);
    b_resp("b_load_word", 32'h11223344);
    b_req(1'b0, 2'd0, 1'b0, 'h6, 32'h0);
    b_resp("b_load_byte", 32'h00000022);

    b_req(1'b0, 2'd2, 1'b0, 'h4, 32'h0);
    @(negedge clk);
    chk("b_midflight_busy", 32'(resp_valid_b), 32'd0);
    @(negedge clk);
    rst_n_b = 1'b0;
    @(negedge clk);
    chk("b_reset_valid", 32'(resp_valid_b), 32'd0);
    chk("b_reset_ready", 32'(req_ready_b), 32'd0);
    chk("b_reset_rdata", resp_rdata_b, 32'h0);
    @(negedge clk);
    rst_n_b = 1'b1;
    @(negedge clk);
    chk("b_ready_after_midreset", 32'(req_ready_b), 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk("b_no_dropped_resp", 32'(resp_valid_b), 32'd0);
      @(negedge clk);
    end

    b_req(1'b1, 2'd2, 1'b0, 'h8, 32'hCAFEF00D);
    @(negedge clk);
    rst_n_b = 1'b0;
    @(negedge clk);
    rst_n_b = 1'b1;
    @(negedge clk);
    b_req(1'b0, 2'd2, 1'b0, 'h8, 32'h0);
    b_resp("b_store_survives_reset", 32'hCAFEF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
